// File: rtl/alu_wb_stage.sv
// ALU result/writeback stage: FIFO-buffered results to the register-file write port plus
// architectural Z/N flags. Define ALU_WB_FWD_EN to add the fwd_* operand-bypass outputs.
module alu_wb_stage #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned RD_W   = 3,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zero,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              flag_z,
  output logic              flag_n
`ifdef ALU_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_result
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [RD_W-1:0]   rd;
    logic              wen;
  } wb_entry_t;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  wb_entry_t        head;
  logic             push;
  logic             pop;

  assign head      = mem[rd_ptr];
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Head presented only while an entry is buffered; zero otherwise.
  assign out_result = out_valid ? head.result : '0;
  assign out_rd     = out_valid ? head.rd     : '0;
  assign out_wen    = out_valid ? head.wen    : 1'b0;

  // Payload storage needs no reset: it is never observed while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{result: in_result, zero: in_zero, rd: in_rd, wen: in_wen};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        flag_z <= head.zero;
        flag_n <= head.result[DATA_W-1];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_WB_FWD_EN
  // Walk oldest to youngest so the youngest register-writing entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    fwd_valid  = 1'b0;
    fwd_rd     = '0;
    fwd_result = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[idx].wen) begin
        fwd_valid  = 1'b1;
        fwd_rd     = mem[idx].rd;
        fwd_result = mem[idx].result;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: reference queue model checked every cycle plus
// directed handshake, flush, reset and (with ALU_WB_FWD_EN) bypass scenarios.
module tb_alu_wb_stage;

  localparam int unsigned DATA_W = 19;
  localparam int unsigned RD_W   = 3;
  localparam int unsigned DEPTH  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic              z;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_result = '0;
  logic              in_zero = 1'b0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              in_wen = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen;
  logic              flag_z;
  logic              flag_n;
`ifdef ALU_WB_FWD_EN
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_result;
`endif

  int   checks = 0;
  int   failures = 0;
  ent_t q[$];
  logic ef_z = 1'b0;
  logic ef_n = 1'b0;

  alu_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .flag_z(flag_z), .flag_n(flag_n)
`ifdef ALU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] r, input logic [RD_W-1:0] rd,
                       input logic wen);
    in_valid  = v;
    in_result = r;
    in_zero   = (r == '0);
    in_rd     = rd;
    in_wen    = wen;
  endtask

  // Check outputs against the model, advance the model, then clock the DUT.
  task automatic cycle();
    bit   push;
    bit   pop;
    ent_t e;
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() == 0) begin
      chk("idle_result", 32'(out_result), 32'(0));
      chk("idle_rd_wen", 32'({out_rd, out_wen}), 32'(0));
    end else begin
      chk("head_result", 32'(out_result), 32'(q[0].r));
      chk("head_rd_wen", 32'({out_rd, out_wen}), 32'({q[0].rd, q[0].wen}));
    end
`ifdef ALU_WB_FWD_EN
    begin
      logic             fv = 1'b0;
      logic [RD_W-1:0]  fr = '0;
      logic [DATA_W-1:0] fd = '0;
      foreach (q[i]) if (q[i].wen) begin fv = 1'b1; fr = q[i].rd; fd = q[i].r; end
      chk("fwd", 32'({fv, fr, fd}), 32'({fwd_valid, fwd_rd, fwd_result}));
    end
`endif
    push = in_valid && (q.size() != DEPTH) && !flush;
    pop  = (q.size() != 0) && out_ready && !flush;
    if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        ef_z = q[0].z;
        ef_n = q[0].r[DATA_W-1];
        void'(q.pop_front());
      end
      if (push) begin
        e = '{r: in_result, rd: in_rd, wen: in_wen, z: in_zero};
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("flag_z", 32'(flag_z), 32'(ef_z));
    chk("flag_n", 32'(flag_n), 32'(ef_n));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    q.delete();
    ef_z = 1'b0;
    ef_n = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_flags", 32'({flag_z, flag_n}), 32'(0));
    chk("rst_out_result", 32'(out_result), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    apply_reset();
    cycle();

    // Single push of a negative result, popped on the following cycle.
    out_ready = 1'b1;
    drive(1'b1, 19'h7FFFF, 3'd3, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    chk("t2_visible", 32'({out_valid, out_result}), 32'({1'b1, 19'h7FFFF}));
    cycle();
    chk("t2_flags", 32'({flag_z, flag_n}), 32'({1'b0, 1'b1}));

    // Stall: two pushes fill the FIFO, third is refused, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 19'h00001, 3'd1, 1'b1);
    cycle();
    drive(1'b1, 19'h00000, 3'd4, 1'b1);
    cycle();
    chk("t3_full", 32'(in_ready), 32'(0));
    drive(1'b1, 19'h3ABCD, 3'd6, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("t3_flags", 32'({flag_z, flag_n}), 32'({1'b1, 1'b0}));
    cycle();

    // Full with simultaneous in_valid and pop: pop only.
    out_ready = 1'b0;
    drive(1'b1, 19'h40002, 3'd2, 1'b0);
    cycle();
    drive(1'b1, 19'h00123, 3'd7, 1'b1);
    cycle();
    drive(1'b1, 19'h11111, 3'd5, 1'b1);
    out_ready = 1'b1;
    cycle();
    chk("t4_ready_after_pop", 32'(in_ready), 32'(1));
    chk("t4_head", 32'(out_result), 32'(19'h00123));
    drive(1'b0, '0, '0, 1'b0);
    cycle();
    cycle();

    // Flush with a coincident pop leaves flags alone.
    out_ready = 1'b0;
    drive(1'b1, 19'h00000, 3'd1, 1'b1);
    cycle();
    drive(1'b1, 19'h7000F, 3'd2, 1'b1);
    cycle();
    drive(1'b1, 19'h00055, 3'd3, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    chk("t5_out_valid", 32'(out_valid), 32'(0));
    chk("t5_flags", 32'({flag_z, flag_n}), 32'({1'b0, 1'b0}));
    cycle();

`ifdef ALU_WB_FWD_EN
    out_ready = 1'b0;
    drive(1'b1, 19'h00010, 3'd2, 1'b1);
    cycle();
    drive(1'b1, 19'h2AAAA, 3'd5, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    chk("t6_fwd", 32'({fwd_valid, fwd_rd, fwd_result}), 32'({1'b1, 3'd2, 19'h00010}));
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t6_fwd_flush", 32'(fwd_valid), 32'(0));
`endif

    // Random traffic, including occasional flushes.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom),
            RD_W'($urandom), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;

    // Reset mid-operation with flags set and an entry buffered.
    out_ready = 1'b1;
    drive(1'b1, 19'h7FFFF, 3'd1, 1'b1);
    cycle();
    out_ready = 1'b0;
    drive(1'b1, 19'h00007, 3'd2, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    apply_reset();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
